line_span_gen: RTL

Rasterises one straight line segment between two arbitrary 9-bit endpoints into a sequence of single-column vertical spans. It sits directly upstream of the vertical-span SPI writer. For each column it presents one column x, with y1 ≤ y2, and pulses a start. It then waits for that writer's done pulse before issuing the next column. The graph-drawing top level uses it to draw every edge with one request per line.

---
 rtl/line_span_gen.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/line_span_gen.sv
// Rasterises one line segment into per-column vertical spans for the span writer.
// All-octant Bresenham walk, one pixel per clock, with a handshake on every emitted span.
module line_span_gen (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic [8:0] i_x0,
    input  logic [8:0] i_y0,
    input  logic [8:0] i_x1,
    input  logic [8:0] i_y1,
    input  logic       i_span_done,
    output logic       o_span_start,
    output logic [8:0] o_x,
    output logic [8:0] o_y1,
    output logic [8:0] o_y2,
    output logic       o_busy,
    output logic       o_done
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        WALK,
        EMIT,
        WAIT,
        DONE
    } state_t;

    state_t state;

    logic [8:0] ax, ay, bx, by;
    logic [8:0] x, y, xe, ye;
    logic [8:0] dx, dy;
    logic [8:0] ymin, ymax;
    logic       up;
    logic       last;
    logic signed [10:0] err;

    logic       swap;
    logic [8:0] sx0, sy0, sx1, sy1;
    logic [8:0] dx_init, dy_init;
    logic       up_init;
    logic signed [10:0] err_init;

    logic signed [11:0] e2, dx_s, dy_s, err_sum;
    logic       step_x, step_y, at_end;
    logic [8:0] x_nxt, y_nxt, ymin_m, ymax_m;

    function automatic logic [8:0] min9(input logic [8:0] a, input logic [8:0] b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic [8:0] max9(input logic [8:0] a, input logic [8:0] b);
        return (a > b) ? a : b;
    endfunction

    // Walk always runs with x increasing; y direction is carried in up.
    always_comb begin
        swap     = ax > bx;
        sx0      = swap ? bx : ax;
        sy0      = swap ? by : ay;
        sx1      = swap ? ax : bx;
        sy1      = swap ? ay : by;
        dx_init  = sx1 - sx0;
        up_init  = sy1 >= sy0;
        dy_init  = up_init ? (sy1 - sy0) : (sy0 - sy1);
        err_init = $signed({2'b00, dx_init}) - $signed({2'b00, dy_init});
    end

    // Both Bresenham decisions use the old e2 so a diagonal step updates x and y together.
    always_comb begin
        dx_s    = $signed({3'b000, dx});
        dy_s    = $signed({3'b000, dy});
        e2      = $signed({err, 1'b0});
        step_x  = e2 > -dy_s;
        step_y  = e2 < dx_s;
        err_sum = $signed({err[10], err});
        if (step_x) begin
            err_sum = err_sum - dy_s;
        end
        if (step_y) begin
            err_sum = err_sum + dx_s;
        end
        x_nxt   = step_x ? (x + 9'd1) : x;
        y_nxt   = y;
        if (step_y) begin
            y_nxt = up ? (y + 9'd1) : (y - 9'd1);
        end
        ymin_m  = min9(ymin, y);
        ymax_m  = max9(ymax, y);
        at_end  = (x == xe) && (y == ye);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state        <= IDLE;
            o_span_start <= 1'b0;
            o_done       <= 1'b0;
            o_busy       <= 1'b0;
            o_x          <= 9'd0;
            o_y1         <= 9'd0;
            o_y2         <= 9'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_start) begin
                        ax     <= i_x0;
                        ay     <= i_y0;
                        bx     <= i_x1;
                        by     <= i_y1;
                        o_busy <= 1'b1;
                        state  <= SETUP;
                    end
                end
                SETUP: begin
                    x     <= sx0;
                    y     <= sy0;
                    xe    <= sx1;
                    ye    <= sy1;
                    dx    <= dx_init;
                    dy    <= dy_init;
                    up    <= up_init;
                    err   <= err_init;
                    ymin  <= sy0;
                    ymax  <= sy0;
                    last  <= 1'b0;
                    state <= WALK;
                end
                WALK: begin
                    if (at_end) begin
                        o_x          <= x;
                        o_y1         <= ymin_m;
                        o_y2         <= ymax_m;
                        o_span_start <= 1'b1;
                        last         <= 1'b1;
                        state        <= EMIT;
                    end else begin
                        err <= err_sum[10:0];
                        x   <= x_nxt;
                        y   <= y_nxt;
                        // The pixel reached by a column step opens the next span.
                        if (step_x) begin
                            o_x          <= x;
                            o_y1         <= ymin_m;
                            o_y2         <= ymax_m;
                            o_span_start <= 1'b1;
                            state        <= EMIT;
                        end else begin
                            ymin <= ymin_m;
                            ymax <= ymax_m;
                        end
                    end
                end
                EMIT: begin
                    o_span_start <= 1'b0;
                    state        <= WAIT;
                end
                WAIT: begin
                    if (i_span_done) begin
                        if (last) begin
                            o_done <= 1'b1;
                            state  <= DONE;
                        end else begin
                            ymin  <= y;
                            ymax  <= y;
                            state <= WALK;
                        end
                    end
                end
                DONE: begin
                    o_done <= 1'b0;
                    o_busy <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
